// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB master port
// between NUM_REQ requesters, with a PREADY timeout.
//
// Ports:
//   PCLK, PRESET         clock, sync active-high reset
//   req_valid/_write     per-requester request and direction
//   req_addr/_wdata      packed 9-bit addr / 8-bit data per requester
//   req_ready            one-hot accept (combinational, IDLE only)
//   rsp_valid            one-hot completion pulse to the owner
//   rsp_rdata/_err       read data / error, valid with rsp_valid
//   PSEL1/PSEL2          slave selects, PADDR[8] picks PSEL2
//   PENABLE/PWRITE       APB enable / direction
//   PADDR/PWDATA         APB address / write data
//   PREADY/PRDATA/PSLVERR  slave response
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [NUM_REQ*9-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL1,
  output logic                 PSEL2,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [8:0]           PADDR,
  output logic [7:0]           PWDATA,
  input  logic                 PREADY,
  input  logic [7:0]           PRDATA,
  input  logic                 PSLVERR
);

  localparam int IW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_REQ =
    IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [IW-1:0]      last_q;
  logic [IW-1:0]      last_d;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;

  logic               psel1_q;
  logic               psel1_d;
  logic               psel2_q;
  logic               psel2_d;
  logic               penable_q;
  logic               penable_d;
  logic               pwrite_q;
  logic               pwrite_d;
  logic [8:0]         paddr_q;
  logic [8:0]         paddr_d;
  logic [7:0]         pwdata_q;
  logic [7:0]         pwdata_d;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [7:0]         rsp_rdata_q;
  logic [7:0]         rsp_rdata_d;
  logic               rsp_err_q;
  logic               rsp_err_d;

  // Arbiter
  logic               gnt_any;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      cand;
  logic               take;

  logic [8:0]         sel_addr;
  logic [7:0]         sel_wdata;
  logic               sel_write;

  logic               done_ok;
  logic               done_to;
  logic               done;

  // Search upward from the slot after the
  // last grant so every requester gets a turn.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign take = (state_q == S_IDLE)
              && !PRESET
              && gnt_any;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (take && (gnt_idx == IW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr  = req_addr[9*i +: 9];
        sel_wdata = req_wdata[8*i +: 8];
        sel_write = req_write[i];
      end
    end
  end

  // PREADY wins over the timeout on the last
  // allowed cycle.
  assign done_ok = (state_q == S_ACCESS)
                 && PREADY;
  assign done_to = (state_q == S_ACCESS)
                 && !PREADY
                 && (cnt_q == CNT_MAX);
  assign done    = done_ok || done_to;

  // State register and datapath registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      last_q      <= LAST_REQ;
      cnt_q       <= '0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    last_d      = last_q;
    cnt_d       = cnt_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        if (take) begin
          paddr_d  = sel_addr;
          pwdata_d = sel_wdata;
          pwrite_d = sel_write;
          psel1_d  = !sel_addr[8];
          psel2_d  = sel_addr[8];
          last_d   = gnt_idx;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        if (done) begin
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = (last_q == IW'(i));
          end
          // Writes and timeouts carry no data.
          rsp_err_d   = done_to | PSLVERR;
          rsp_rdata_d = (done_to || pwrite_q)
                      ? 8'h00 : PRDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
